mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4:1 DW-bit multiplexed datapath among 4 requesters.
//  Registers the grant and drives the mux select. Presents the selected requester's data
//  downstream with a valid/ready handshake. Sits between the 4 producer ports and the
//  single shared consumer.
// PARAMETERS
//  DW  8  data width of each requester port and of out_data
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  req        in   4      req[i]=1: requester i has data pending; holds until acked
//  din        in   4*DW   packed requester data; din[i*DW +: DW] belongs to requester i
//  out_ready  in   1      consumer can accept out_data this cycle
//  lock       in   4      (ARB_LOCK_EN only) lock[i]=1: keep grant on i after transfer
//  gnt        out  4      one-hot registered grant; gnt[i] & out_ready = ack to requester i
//  sel        out  2      registered index of the granted requester (mux select)
//  out_valid  out  1      out_data is valid (= |gnt)
//  out_data   out  DW     din[sel*DW +: DW] when out_valid, else 0
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE, gnt=0, sel=0, out_valid=0, rr_ptr=0.
//    Reset overrides any in-flight grant; the pending transfer is dropped, not completed.
//  - States: IDLE (no grant), BUSY (one grant held).
//  - IDLE: if |req, pick the first set req[k] scanning k = rr_ptr, rr_ptr+1, ... mod 4.
//    Next cycle: gnt=1<<k, sel=k, state=BUSY. Latency from req to out_valid is 1 cycle.
//  - BUSY, transfer (out_valid & out_ready): rr_ptr <= sel+1 (mod 4, 2-bit wrap 3->0).
//    Re-arbitrate in the same cycle against current req, masking req[sel].
//    If another request exists: grant it next cycle (back-to-back, no bubble).
//    Otherwise: state=IDLE, gnt=0. A requester re-requesting immediately waits one idle cycle.
//  - BUSY, no transfer, req[sel]=1: hold gnt/sel/out_data stable (stall).
//  - BUSY, req[sel] drops before transfer: abort. gnt=0, state=IDLE next cycle.
//    rr_ptr is unchanged and no transfer is counted.
//  - out_data is combinational from registered sel and live din. Requesters hold din
//    stable while req=1.
//  - All req=0 in IDLE: stay IDLE, outputs 0. At most one gnt bit set, ever.
//  - Fairness: with all 4 requesting continuously and out_ready=1, grants rotate
//    0,1,2,3,0... with one transfer per cycle.
// CONFIGURATION
//  ARB_LOCK_EN defined: lock port exists. On transfer with lock[sel]=1 and req[sel]=1,
//    the grant stays on sel and rr_ptr is not advanced (multi-beat burst).
//    Dropping lock releases the grant at the next transfer as normal.
//  ARB_LOCK_EN undefined: no lock port; every transfer advances rr_ptr and re-arbitrates.
// STRUCTURE
//  Package mux_arb_pkg: NREQ=4 localparam, SELW=2, typedef enum logic {IDLE,BUSY} arb_state_t.
//  Sub-module mux4_bus #(DW): combinational 4:1 DW-bit data mux (d0..d3, s[1:0], f),
//    built as a tree of three 2:1 stages. Instantiated once for out_data.
//  Round-robin pick function (rotate by rr_ptr, priority encode, rotate back) lives in
//    mux_arb_pkg.
// TESTING
//  1 rst=1 with req=4'hF -> gnt=0, out_valid=0, sel=0. Release rst -> next cycle gnt=0001.
//  2 req=4'hF held, out_ready=1, din={8'h44,8'h33,8'h22,8'h11} -> out_data 11,22,33,44,11
//    on consecutive cycles; gnt 1,2,4,8,1.
//  3 req=4'b0100, out_ready=0 for 3 cycles -> gnt=0100, out_data=din[2] stable 3 cycles;
//    out_ready=1 -> transfer, then IDLE.
//  4 Grant on 3, transfer -> rr_ptr wraps to 0; req=4'b1001 -> next grant is 0, not 3.
//  5 Grant on 1, drop req[1] before out_ready -> gnt=0 next cycle, rr_ptr still 1.
//    Mid-BUSY rst=1 -> all outputs 0 next cycle.
//  6 (ARB_LOCK_EN) req=4'hF, lock=4'b0001, out_ready=1 -> gnt stays 0001 while locked;
//    clear lock -> next grant 0010.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_arb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Round-robin pick: rotate requests so rr_ptr lands at bit 0, take the lowest set
  // bit, then rotate the index back. Result is {found, index}.
  function automatic logic [SELW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [SELW-1:0] ptr);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SELW:0]     res;
    dbl = {r, r} >> ptr;
    rot = dbl[NREQ-1:0];
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) res = {1'b1, SELW'(i) + ptr};
    end
    return res;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_bus.sv
// Combinational 4:1 DW-bit data mux built as a tree of three 2:1 stages.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows s and d0..d3 directly.
module mux4_bus #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic [1:0]    s,
  output logic [DW-1:0] f
);

  logic [DW-1:0] lo;
  logic [DW-1:0] hi;

  // First stage picks within each pair, second stage picks the pair.
  assign lo = s[0] ? d1 : d0;
  assign hi = s[0] ? d3 : d2;
  assign f  = s[1] ? hi : lo;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 DW-bit datapath; optional burst lock via ARB_LOCK_EN.
// Latency: 1 cycle req -> out_valid; back-to-back grants with no bubble on transfer.
// Backpressure: grant, sel and out_data hold while out_ready=0 and the requester keeps req.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  input  logic                 out_ready,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]      lock,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data
);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [SELW-1:0] sel_nxt;
  logic [SELW-1:0] rr_ptr, rr_ptr_nxt;
  logic [SELW-1:0] sel_inc;
  logic [SELW:0]   pick_idle;
  logic [SELW:0]   pick_next;
  logic            xfer;
  logic            keep;
  logic [DW-1:0]   mux_f;

  assign out_valid = |gnt;
  assign xfer      = out_valid & out_ready;
  assign sel_inc   = sel + 2'd1;

  // From IDLE scan from rr_ptr; after a transfer scan from the slot past the winner,
  // excluding the requester that was just served.
  assign pick_idle = rr_pick(req, rr_ptr);
  assign pick_next = rr_pick(req & ~gnt, sel_inc);

`ifdef ARB_LOCK_EN
  assign keep = lock[sel] & req[sel];
`else
  assign keep = 1'b0;
`endif

  // Next-state, grant, select and pointer decisions.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    sel_nxt    = sel;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_idle[SELW]) begin
          gnt_nxt   = onehot(pick_idle[SELW-1:0]);
          sel_nxt   = pick_idle[SELW-1:0];
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (!keep) begin
            rr_ptr_nxt = sel_inc;
            if (pick_next[SELW]) begin
              gnt_nxt = onehot(pick_next[SELW-1:0]);
              sel_nxt = pick_next[SELW-1:0];
            end else begin
              gnt_nxt   = '0;
              state_nxt = IDLE;
            end
          end
        end else if (!req[sel]) begin
          // Requester withdrew before being served: release without advancing rr_ptr.
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      sel    <= sel_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  mux4_bus #(.DW(DW)) u_mux (
    .d0 (din[0*DW +: DW]),
    .d1 (din[1*DW +: DW]),
    .d2 (din[2*DW +: DW]),
    .d3 (din[3*DW +: DW]),
    .s  (sel),
    .f  (mux_f)
  );

  assign out_data = out_valid ? mux_f : '0;

endmodule
